// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, FSM state
// encodings and the fixed 16-bit instruction layout.
package rf_seq_pkg;

  // Opcodes. Anything above OP_SHL is undefined.
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_LDI = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;

  // Sequencer states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  // Instruction field positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int DST_MSB = 11;
  localparam int DST_LSB = 10;
  localparam int SA_MSB  = 9;
  localparam int SA_LSB  = 8;
  localparam int SB_MSB  = 7;
  localparam int SB_LSB  = 6;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;

  // Decoded view of a 16-bit instruction word
  typedef struct packed {
    logic [3:0] op;
    logic [1:0] dest;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [5:0] imm;
  } instr_t;

  function automatic instr_t decode(input logic [15:0] w);
    instr_t d;
    d.op    = w[OP_MSB:OP_LSB];
    d.dest  = w[DST_MSB:DST_LSB];
    d.src_a = w[SA_MSB:SA_LSB];
    d.src_b = w[SB_MSB:SB_LSB];
    d.imm   = w[IMM_MSB:IMM_LSB];
    return d;
  endfunction

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational execute unit: (op, a, b, imm) -> (result, write_en, illegal).
module rf_seq_alu
  import rf_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [5:0]            i_imm,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_write_en,
  output logic                  o_illegal
);

  // Arithmetic wraps and shifts drop overflow bits naturally at DATA_WIDTH.
  always_comb begin
    o_result   = '0;
    o_write_en = 1'b1;
    o_illegal  = 1'b0;
    case (i_op)
      OP_NOP: o_write_en = 1'b0;
      OP_ADD: o_result = i_a + i_b;
      OP_SUB: o_result = i_a - i_b;
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_LDI: o_result = DATA_WIDTH'(i_imm);
      OP_MOV: o_result = i_a;
      OP_SHL: o_result = i_a << i_imm[4:0];
      default: begin
        o_write_en = 1'b0;
        o_illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rf_sequencer.sv
// Register-file initiator: accepts one instruction at a time, reads two
// operands, executes, and writes the result back in a fixed 4-cycle loop.
module rf_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 2,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   instr_valid,
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_ready,
  output logic [SEL_WIDTH-1:0]   A_select,
  output logic [SEL_WIDTH-1:0]   B_select,
  input  logic [DATA_WIDTH-1:0]  A_data,
  input  logic [DATA_WIDTH-1:0]  B_data,
  output logic [SEL_WIDTH-1:0]   dest_select,
  output logic [DATA_WIDTH-1:0]  D_data,
  output logic                   load_enable,
  output logic                   busy,
  output logic                   illegal_op
);

  logic [1:0]            r_state;
  logic [3:0]            r_op;
  logic [1:0]            r_dest;
  logic [5:0]            r_imm;
  logic [DATA_WIDTH-1:0] r_opa;
  logic [DATA_WIDTH-1:0] r_opb;

  instr_t                w_word;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_we;
  logic                  w_ill;

  // The field layout is fixed at 16 bits.
  assign w_word = decode(instr[15:0]);

  rf_seq_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .i_op       (r_op),
    .i_a        (r_opa),
    .i_b        (r_opb),
    .i_imm      (r_imm),
    .o_result   (w_result),
    .o_write_en (w_we),
    .o_illegal  (w_ill)
  );

  // Sequencer FSM. Selects are registered on the accept edge so they are
  // already stable in READ; D_data is the registered ALU result and, with
  // dest_select, only moves on a real write so both hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_NOP;
      r_dest      <= '0;
      r_imm       <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      A_select    <= '0;
      B_select    <= '0;
      dest_select <= '0;
      D_data      <= '0;
      load_enable <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      load_enable <= 1'b0;
      illegal_op  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_op        <= w_word.op;
            r_dest      <= w_word.dest;
            r_imm       <= w_word.imm;
            A_select    <= SEL_WIDTH'(w_word.src_a);
            B_select    <= SEL_WIDTH'(w_word.src_b);
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            r_state     <= ST_READ;
          end
        end
        ST_READ: begin
          r_opa   <= A_data;
          r_opb   <= B_data;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          load_enable <= w_we;
          illegal_op  <= w_ill;
          if (w_we) begin
            dest_select <= SEL_WIDTH'(r_dest);
            D_data      <= w_result;
          end
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer with a behavioural register file attached and a
// cycle-by-cycle reference model of the instruction loop.
module tb_rf_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready, load_enable, busy, illegal_op;
  logic [1:0]  A_select, B_select, dest_select;
  logic [31:0] A_data, B_data, D_data;
  logic [31:0] rf [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rf_sequencer #(.DATA_WIDTH(32), .SEL_WIDTH(2), .INSTR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .A_select(A_select), .B_select(B_select),
    .A_data(A_data), .B_data(B_data), .dest_select(dest_select),
    .D_data(D_data), .load_enable(load_enable), .busy(busy),
    .illegal_op(illegal_op)
  );

  // Register file on the other side of the interface
  assign A_data = rf[A_select];
  assign B_data = rf[B_select];
  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 4; i++) rf[i] <= '0;
    else if (load_enable) rf[dest_select] <= D_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int d, input int a, input int b, input int imm);
    return {4'(op), 2'(d), 2'(a), 2'(b), 6'(imm)};
  endfunction

  function automatic bit writes(input logic [15:0] w);
    return (w[15:12] >= 4'd1) && (w[15:12] <= 4'd8);
  endfunction

  function automatic logic [31:0] f_res(input logic [15:0] w, input logic [31:0] a, input logic [31:0] b);
    logic [5:0] imm;
    imm = w[5:0];
    case (w[15:12])
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a ^ b;
      4'd6: return {26'd0, imm};
      4'd7: return a;
      4'd8: return a << imm[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: an accepted word occupies edges hs..hs+3; the write
  // appears in the third cycle after acceptance (phase 2 below).
  int          e = 1;
  int          hs = -100;
  logic [15:0] cur = '0;
  bit          mvalid = 0;
  logic [31:0] mr [4];
  logic [1:0]  msa = '0, msb = '0, mdst = '0;
  logic [31:0] mdat = '0, mres = '0;
  int          dut_hs [$];

  always @(negedge clk) begin
    int ph;
    bit infl, wr;
    ph   = e - hs;
    infl = (ph >= 0) && (ph <= 2);
    wr   = writes(cur);
    if (mvalid) begin
      chk("instr_ready", instr_ready, !infl);
      chk("busy", busy, infl);
      chk("load_enable", load_enable, infl && ph == 2 && wr);
      chk("illegal_op", illegal_op, infl && ph == 2 && cur[15:12] >= 4'd9);
      chk("A_select", A_select, msa);
      chk("B_select", B_select, msb);
      if (infl && ph == 2 && wr) begin
        chk("dest_select", dest_select, cur[11:10]);
        chk("D_data", D_data, mres);
      end else begin
        chk("dest_hold", dest_select, mdst);
        chk("D_hold", D_data, mdat);
      end
      for (int i = 0; i < 4; i++) chk("regfile", rf[i], mr[i]);
    end
    if (instr_valid && instr_ready && !reset) dut_hs.push_back(e + 1);
    if (reset) begin
      mvalid = 1; hs = -100; cur = '0;
      msa = '0; msb = '0; mdst = '0; mdat = '0;
      for (int i = 0; i < 4; i++) mr[i] = '0;
    end else if (mvalid) begin
      if (infl && ph == 2 && wr) begin
        mr[cur[11:10]] = mres; mdst = cur[11:10]; mdat = mres;
      end
      if (instr_valid && !infl) begin
        hs = e + 1; cur = instr; msa = instr[9:8]; msb = instr[7:6];
        mres = f_res(instr, mr[instr[9:8]], mr[instr[7:6]]);
      end
    end
    e++;
  end

  // Issue one word and check the WRITE cycle against literal expectations.
  task automatic issue(input logic [15:0] w, input logic exp_we, input logic [1:0] d,
                       input logic [31:0] v, input logic exp_ill);
    int n = 0;
    instr_valid = 1'b1; instr = w;
    @(negedge clk);
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!instr_ready) chk("handshake_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 16'($urandom);
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("lit_load_enable", load_enable, exp_we);
    chk("lit_illegal_op", illegal_op, exp_ill);
    if (exp_we) begin
      chk("lit_dest", dest_select, d);
      chk("lit_D_data", D_data, v);
    end
    @(negedge clk);
    chk("lit_ready_back", instr_ready, 1'b1);
    chk("lit_le_low", load_enable, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] words [4];
    int k, n;
    bit f;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_D_data", D_data, 32'd0);
    @(posedge clk); #1;

    issue(enc(6, 1, 0, 0, 5), 1'b1, 2'd1, 32'd5, 1'b0);
    chk("lit_r1", rf[1], 32'd5);
    issue(enc(1, 2, 1, 1, 0), 1'b1, 2'd2, 32'd10, 1'b0);
    issue(enc(2, 3, 0, 2, 0), 1'b1, 2'd3, 32'hFFFF_FFF6, 1'b0);
    issue(enc(8, 0, 1, 0, 31), 1'b1, 2'd0, 32'h8000_0000, 1'b0);
    issue(enc(5, 1, 1, 1, 0), 1'b1, 2'd1, 32'd0, 1'b0);
    issue(16'hF000, 1'b0, 2'd0, 32'd0, 1'b1);
    chk("lit_r0_kept", rf[0], 32'h8000_0000);
    chk("lit_r3_kept", rf[3], 32'hFFFF_FFF6);

    // Reset while LDI r2,#9 is in EXEC
    instr_valid = 1'b1; instr = enc(6, 2, 0, 0, 9);
    @(negedge clk);
    @(posedge clk); #1 instr_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rstx_ready", instr_ready, 1'b1);
    chk("rstx_le", load_enable, 1'b0);
    chk("rstx_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) chk("rstx_reg", rf[i], 32'd0);
    repeat (4) begin @(negedge clk); chk("rstx_no_write", load_enable, 1'b0); end
    @(posedge clk); #1;

    // Four words with valid held high
    for (int i = 0; i < 4; i++) words[i] = {4'($urandom_range(1, 8)), 12'($urandom)};
    dut_hs.delete();
    k = 0; n = 0;
    instr_valid = 1'b1; instr = words[0];
    while (k < 4 && n < 60) begin
      @(negedge clk); f = instr_valid && instr_ready;
      @(posedge clk); #1; n++;
      if (f) begin
        k++;
        if (k == 4) instr_valid = 1'b0; else instr = words[k];
      end
    end
    chk("queue_accepted", dut_hs.size(), 32'd4);
    for (int i = 1; i < dut_hs.size(); i++) chk("queue_spacing", dut_hs[i] - dut_hs[i-1], 32'd4);
    repeat (4) @(posedge clk); #1;

    // Randomized traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      @(negedge clk); f = instr_valid && instr_ready && !reset;
      @(posedge clk); #1;
      reset = ($urandom_range(0, 99) < 2);
      if (f || !instr_valid) begin
        instr = {4'($urandom_range(0, 10)), 12'($urandom)};
        instr_valid = ($urandom_range(0, 3) != 0);
      end
    end
    reset = 1'b0; instr_valid = 1'b0;
    repeat (6) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
